univ_shift_engine: RTL and testbench
====================================

Name: univ_shift_engine

Overview:
- Parametrised multi-step universal shift register, the next generation of the board-level shifter experiment.
- One start command runs a programmed number of shift steps, paced by an external step tick such as a debounced manual clock pulse.
- Adds rotate and arithmetic modes, serial-out capture, busy/done/abort handshake, and step counting.
- Sits between the LCD/touch input register bank (supplies din, mode, count, serial inputs) and the LCD display mux (reads dout, busy, done, shift_out, steps_done).

Parameters:
- WIDTH, 8: data register width in bits (WIDTH >= 2).
- CNT_W, 4: width of the shift-count field; max steps per command = 2^CNT_W - 1.

Ports:
- clk  input  1  system clock.
- resetn  input  1  synchronous active-low reset.
- din  input  WIDTH  parallel load data.
- mode  input  3  operation select, latched at start.
- count  input  CNT_W  number of shift steps, latched at start.
- srsi  input  1  serial input for right shift.
- slsi  input  1  serial input for left shift.
- start  input  1  command request, single-cycle or level.
- step_en  input  1  one shift per cycle high while running.
- abort  input  1  cancel running command.
- dout  output  WIDTH  shift register contents.
- shift_out  output  1  bit shifted out on the most recent step.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse.
- steps_done  output  CNT_W  steps executed in the current or last command.

Behaviour:
- Reset and clocking:
  - Reset is resetn, synchronous, active-low; clock is clk. All state updates on posedge clk.
  - While resetn is low, the next edge forces dout=0, shift_out=0, busy=0, done=0, steps_done=0, state=IDLE, latched mode/count=0.
  - Reset mid-RUN discards the command; no done pulse.
- Mode encoding (latched at start):
  - 000: hold.
  - 001: shift right logical, MSB<=srsi.
  - 010: shift left, LSB<=slsi.
  - 011: parallel load.
  - 100: rotate right.
  - 101: rotate left.
  - 110: arithmetic right, MSB replicated.
  - 111: reserved, treated as hold.
- States: IDLE, RUN. busy = (state==RUN).
- IDLE, start=1:
  - Load (011): dout<=din, steps_done<=0, done<=1 at the next edge; stays IDLE; busy never asserts.
  - Hold, reserved, or count==0: dout unchanged, steps_done<=0, done<=1 next edge; stays IDLE.
  - Other modes with count>0: latch mode and count, steps_done<=0, state<=RUN. busy is high from the next cycle.
- RUN:
  - Each edge with step_en=1 and abort=0 performs one shift and increments steps_done.
  - srsi/slsi are sampled live at each step edge, not latched at start.
  - shift_out <= the bit leaving the register: LSB for right/rotate-right/arithmetic, MSB for left/rotate-left. For rotates it equals the wrapped bit.
  - On the step edge where steps_done reaches the latched count: state<=IDLE and done<=1, on the same edge as the final dout update.
  - step_en held high for N cycles gives N steps; a step tick in IDLE is ignored.
- start while busy is ignored; mode/count/din changes during RUN have no effect.
- abort in RUN: state<=IDLE next edge, dout/shift_out/steps_done keep partial values, done stays 0. abort takes precedence over a simultaneous step_en (no shift). abort in IDLE is ignored.
- done is high for exactly one cycle, then returns to 0 unless a new start in IDLE re-asserts it on the following edge.
- Latency: load/zero-count completes 1 cycle after start. A shift command completes on the edge of its count-th accepted step.

Test Plan:
- Reset: resetn low 2 cycles -> dout=0x00, busy=0, done=0, steps_done=0, shift_out=0.
- Load: din=0xA5, mode=011, start 1 cycle -> next edge dout=0xA5, done=1 for one cycle, busy stays 0.
- Right shift: from dout=0xA5, mode=001, srsi=1, count=3, start, three spaced step_en pulses -> dout 0xD2, 0xE9, 0xF4; shift_out=1 after the last step; done pulses on the 3rd step edge; busy=0 after it; steps_done=3.
- Rotates and arithmetic:
  - dout=0x81, mode=101, count=2 -> 0x03 then 0x06, shift_out=0 at the end.
  - dout=0x80, mode=110, count=3 -> 0xF0.
  - step_en held high 3 cycles -> 3 steps, completes in 3 cycles.
- Abort/ignore: dout=0x0F, mode=010, slsi=0, count=4, one step -> dout=0x1E. Then a second start while busy -> ignored. Then abort with step_en=1 on the same edge -> dout stays 0x1E, busy=0, done never pulses, steps_done=1.
- Boundaries:
  - count=0 with mode=001 -> done pulse next edge, dout unchanged.
  - resetn low during RUN after 2 of 5 steps -> all outputs 0 next edge, no done.
  - count=15 (max, CNT_W=4) -> completes on the 15th step; steps_done=15 with no wrap.

Source files
------------

// File: rtl/univ_shift_engine.sv
// Multi-step universal shift register: one start command runs a programmed
// number of shift/rotate steps paced by step_en_i, with abort and done handshake.
module univ_shift_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din_i,
  input  logic [2:0]       mode_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             srsi_i,
  input  logic             slsi_i,
  input  logic             start_i,
  input  logic             step_en_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             shift_out_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] steps_done_o
);

  // state  | meaning
  // S_IDLE | waiting for start; load/hold/zero-count commands finish here
  // S_RUN  | shift command in progress, one shift per step_en_i cycle
  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             shift_out_q, shift_out_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] shift_val;
  logic             shift_bit;
  logic             start_is_shift;
  logic [CNT_W-1:0] steps_inc;

  assign start_is_shift = (mode_i == M_SHR) || (mode_i == M_SHL) || (mode_i == M_ROR) ||
                          (mode_i == M_ROL) || (mode_i == M_ASR);
  assign steps_inc = steps_q + CNT_W'(1);

  always_comb begin
    shift_val = dout_q;
    shift_bit = shift_out_q;
    case (mode_q)
      M_SHR: begin
        shift_val = {srsi_i, dout_q[WIDTH-1:1]};
        shift_bit = dout_q[0];
      end
      M_SHL: begin
        shift_val = {dout_q[WIDTH-2:0], slsi_i};
        shift_bit = dout_q[WIDTH-1];
      end
      M_ROR: begin
        shift_val = {dout_q[0], dout_q[WIDTH-1:1]};
        shift_bit = dout_q[0];
      end
      M_ROL: begin
        shift_val = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
        shift_bit = dout_q[WIDTH-1];
      end
      M_ASR: begin
        shift_val = {dout_q[WIDTH-1], dout_q[WIDTH-1:1]};
        shift_bit = dout_q[0];
      end
      default: begin
        shift_val = dout_q;
        shift_bit = shift_out_q;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dout_d      = dout_q;
    shift_out_d = shift_out_q;
    done_d      = 1'b0;
    steps_d     = steps_q;
    mode_d      = mode_q;
    count_d     = count_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          steps_d = '0;
          if (mode_i == M_LOAD) begin
            dout_d = din_i;
            done_d = 1'b1;
          end else if (!start_is_shift || count_i == '0) begin
            done_d = 1'b1;
          end else begin
            mode_d  = mode_i;
            count_d = count_i;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        // abort wins over a coincident step and leaves partial results visible
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (step_en_i) begin
          dout_d      = shift_val;
          shift_out_d = shift_bit;
          steps_d     = steps_inc;
          if (steps_inc == count_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      dout_q      <= '0;
      shift_out_q <= 1'b0;
      done_q      <= 1'b0;
      steps_q     <= '0;
      mode_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      dout_q      <= dout_d;
      shift_out_q <= shift_out_d;
      done_q      <= done_d;
      steps_q     <= steps_d;
      mode_q      <= mode_d;
      count_q     <= count_d;
    end
  end

  assign dout_o       = dout_q;
  assign shift_out_o  = shift_out_q;
  assign busy_o       = (state_q == S_RUN);
  assign done_o       = done_q;
  assign steps_done_o = steps_q;

endmodule

// File: tb/tb_univ_shift_engine.sv
// Scoreboard bench for univ_shift_engine: commands push their expected completion,
// a done-driven monitor pops and compares; per-step and boundary checks run inline.
module tb_univ_shift_engine;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] din_i;
  logic [2:0] mode_i;
  logic [3:0] count_i;
  logic       srsi_i, slsi_i, start_i, step_en_i, abort_i;
  logic [7:0] dout_o;
  logic       shift_out_o, busy_o, done_o;
  logic [3:0] steps_done_o;

  univ_shift_engine #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn), .din_i(din_i), .mode_i(mode_i), .count_i(count_i),
    .srsi_i(srsi_i), .slsi_i(slsi_i), .start_i(start_i), .step_en_i(step_en_i),
    .abort_i(abort_i), .dout_o(dout_o), .shift_out_o(shift_out_o), .busy_o(busy_o),
    .done_o(done_o), .steps_done_o(steps_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int st;
    int so;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   m_dout = 0;
  int   m_so = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // reference step: value is an integer 0..255, arithmetic only
  task automatic model_step(input int md, input int v, input int sr, input int sl,
                            output int nv, output int ob);
    nv = v;
    ob = 0;
    case (md)
      1: begin ob = v % 2;   nv = v / 2 + sr * 128; end
      2: begin ob = v / 128; nv = (v * 2) % 256 + sl; end
      4: begin ob = v % 2;   nv = v / 2 + ob * 128; end
      5: begin ob = v / 128; nv = (v * 2) % 256 + ob; end
      6: begin ob = v % 2;   nv = v / 2 + ((v >= 128) ? 128 : 0); end
      default: begin nv = v; ob = 0; end
    endcase
  endtask

  always @(negedge clk) begin
    if (resetn === 1'b1 && done_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected actual=done=1 required=no_done dout=0x%0h", dout_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(dout_o) != mon_e.d || int'(steps_done_o) != mon_e.st ||
            int'(shift_out_o) != mon_e.so || busy_o !== 1'b0) begin
          failures++;
          $display("FAIL done_result actual=dout=0x%0h steps=%0d so=%0d busy=%0d required=dout=0x%0h steps=%0d so=%0d busy=0",
                   dout_o, steps_done_o, shift_out_o, busy_o, mon_e.d, mon_e.st, mon_e.so);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // si < 0: random serial inputs per step, otherwise that value on both
  task automatic run_cmd(input int md, input int cnt, input int din, input int si, input int gapmax);
    int   inter[16];
    int   sr[16];
    int   sl[16];
    int   v, nv, ob, so;
    exp_t e;
    bit   shiftable;
    shiftable = (md == 1 || md == 2 || md == 4 || md == 5 || md == 6);
    start_i = 1'b1;
    mode_i  = 3'(md);
    count_i = 4'(cnt);
    din_i   = 8'(din);
    step_en_i = 1'b0;
    if (md == 3) begin
      e.d = din; e.st = 0; e.so = m_so;
      exp_q.push_back(e);
      m_dout = din;
      tick();
      start_i = 1'b0;
      chk("load_busy", int'(busy_o), 0);
      return;
    end
    if (!shiftable || cnt == 0) begin
      e.d = m_dout; e.st = 0; e.so = m_so;
      exp_q.push_back(e);
      tick();
      start_i = 1'b0;
      chk("nop_busy", int'(busy_o), 0);
      return;
    end
    v = m_dout;
    so = m_so;
    for (int i = 0; i < cnt; i++) begin
      sr[i] = (si < 0) ? int'($urandom_range(0, 1)) : si;
      sl[i] = (si < 0) ? int'($urandom_range(0, 1)) : si;
      model_step(md, v, sr[i], sl[i], nv, ob);
      v = nv;
      so = ob;
      inter[i] = v;
    end
    e.d = v; e.st = cnt; e.so = so;
    exp_q.push_back(e);
    tick();
    start_i = 1'b0;
    mode_i  = 3'($urandom);
    count_i = 4'($urandom);
    din_i   = 8'($urandom);
    chk("run_busy", int'(busy_o), 1);
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(0, gapmax)) begin
        step_en_i = 1'b0;
        srsi_i = 1'($urandom);
        slsi_i = 1'($urandom);
        tick();
      end
      step_en_i = 1'b1;
      srsi_i = 1'(sr[i]);
      slsi_i = 1'(sl[i]);
      tick();
      step_en_i = 1'b0;
      chk("step_dout", int'(dout_o), inter[i]);
      chk("step_count", int'(steps_done_o), i + 1);
    end
    chk("end_busy", int'(busy_o), 0);
    m_dout = v;
    m_so = so;
  endtask

  initial begin
    resetn = 1'b0; din_i = '0; mode_i = '0; count_i = '0;
    srsi_i = 1'b0; slsi_i = 1'b0; start_i = 1'b0; step_en_i = 1'b0; abort_i = 1'b0;
    tick(); tick();
    chk("rst_dout", int'(dout_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_steps", int'(steps_done_o), 0);
    chk("rst_so", int'(shift_out_o), 0);
    resetn = 1'b1;
    tick();

    // load, with a one-cycle done
    run_cmd(3, 0, 8'hA5, 0, 0);
    chk("load_dout", int'(dout_o), 8'hA5);
    chk("load_done", int'(done_o), 1);
    tick();
    chk("load_done_clr", int'(done_o), 0);

    run_cmd(1, 3, 0, 1, 2);
    chk("shr_dout", int'(dout_o), 8'hF4);
    chk("shr_so", int'(shift_out_o), 1);
    chk("shr_steps", int'(steps_done_o), 3);
    tick();

    run_cmd(3, 0, 8'h81, 0, 0);
    run_cmd(5, 2, 0, 0, 1);
    chk("rol_dout", int'(dout_o), 8'h06);
    chk("rol_so", int'(shift_out_o), 0);

    run_cmd(3, 0, 8'h80, 0, 0);
    run_cmd(6, 3, 0, 0, 0);
    chk("asr_dout", int'(dout_o), 8'hF0);

    // abort path
    run_cmd(3, 0, 8'h0F, 0, 0);
    start_i = 1'b1; mode_i = 3'b010; count_i = 4'd4; slsi_i = 1'b0;
    tick();
    start_i = 1'b0;
    step_en_i = 1'b1;
    tick();
    step_en_i = 1'b0;
    chk("abt_step", int'(dout_o), 8'h1E);
    start_i = 1'b1; mode_i = 3'b011; din_i = 8'h55;
    tick();
    start_i = 1'b0;
    chk("busy_start_dout", int'(dout_o), 8'h1E);
    chk("busy_start_busy", int'(busy_o), 1);
    abort_i = 1'b1; step_en_i = 1'b1;
    tick();
    abort_i = 1'b0; step_en_i = 1'b0;
    chk("abt_dout", int'(dout_o), 8'h1E);
    chk("abt_busy", int'(busy_o), 0);
    chk("abt_steps", int'(steps_done_o), 1);
    chk("abt_done", int'(done_o), 0);
    m_dout = 8'h1E; m_so = 0;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("idle_abort_dout", int'(dout_o), 8'h1E);

    run_cmd(1, 0, 0, 1, 0);
    chk("cnt0_dout", int'(dout_o), 8'h1E);

    // reset mid-run after 2 of 5 steps
    run_cmd(3, 0, 8'h3C, 0, 0);
    start_i = 1'b1; mode_i = 3'b001; count_i = 4'd5; srsi_i = 1'b1;
    tick();
    start_i = 1'b0;
    step_en_i = 1'b1;
    tick(); tick();
    step_en_i = 1'b0;
    chk("pre_rst_steps", int'(steps_done_o), 2);
    resetn = 1'b0;
    tick();
    chk("mid_rst_dout", int'(dout_o), 0);
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_steps", int'(steps_done_o), 0);
    chk("mid_rst_done", int'(done_o), 0);
    resetn = 1'b1;
    m_dout = 0; m_so = 0;
    tick();
    chk("post_rst_done", int'(done_o), 0);

    run_cmd(3, 0, 8'hC3, 0, 0);
    run_cmd(1, 15, 0, -1, 0);
    chk("max_steps", int'(steps_done_o), 15);

    for (int k = 0; k < 40; k++) begin
      run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 255)), -1, 2);
      if ($urandom_range(0, 1) == 1) tick();
    end

    tick(); tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
